cpu_control_fsm: RTL and testbench

Multi-cycle control unit for the MiniRiscV core: fetches an instruction over a req/ack handshake, decodes it, and sequences EXECUTE/MEM/WB while driving the ALU's control inputs (ALUOp, ALUSrc, funct3, funct7, imm32). It sits upstream of the ALU. It consumes `doBranch` and honours the ALU's one-cycle registered result latency. It also drives register-file, data-memory and PC control, and counts retired instructions.

---
 rtl/cpu_control_fsm_if.sv | 26 ++
 rtl/cpu_control_fsm.sv | 167 ++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_control_fsm_if.sv
// Instruction/data memory handshake bundle for cpu_control_fsm.
//   instr     : instruction word, valid while imem_ack=1
//   imem_req  : fetch request (control unit -> imem)
//   imem_ack  : fetch completes this cycle (imem -> control unit)
//   MemRead   : load strobe, held until dmem_ack
//   MemWrite  : store strobe, held until dmem_ack
//   dmem_ack  : load/store completes this cycle (dmem -> control unit)
// master = control unit side, slave = memory side.
interface cpu_control_fsm_if;
   logic [31:0] instr;
   logic        imem_req;
   logic        imem_ack;
   logic        MemRead;
   logic        MemWrite;
   logic        dmem_ack;

   modport master (
      input  instr, imem_ack, dmem_ack,
      output imem_req, MemRead, MemWrite
   );

   modport slave (
      output instr, imem_ack, dmem_ack,
      input  imem_req, MemRead, MemWrite
   );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit for the MiniRiscV core.
// Fetches over the bus handshake, decodes, then sequences EXECUTE/MEM/WB while
// driving the ALU controls, register-file/data-memory strobes and PC update.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   bus (master)      : instr/imem_req/imem_ack, MemRead/MemWrite/dmem_ack
//   doBranch          : ALU branch condition (used in EXECUTE of a branch)
//   ALUOp, ALUSrc, funct3, funct7, imm32 : ALU controls, stable DECODE..end
//   rs1, rs2, rd      : register indices
//   RegWrite, MemtoReg: write-back strobes
//   pc_we, pc_sel     : PC update pulse and source (0=PC+4, 1=PC+imm32)
//   illegal           : sticky illegal-opcode flag (TRAP state)
//   retired           : retired-instruction counter (wraps)
//   state             : current FSM state for debug
module cpu_control_fsm (
   input  logic                clk,
   input  logic                rst,
   cpu_control_fsm_if.master   bus,
   input  logic                doBranch,
   output logic [1:0]          ALUOp,
   output logic                ALUSrc,
   output logic [2:0]          funct3,
   output logic [6:0]          funct7,
   output logic [31:0]         imm32,
   output logic [4:0]          rs1,
   output logic [4:0]          rs2,
   output logic [4:0]          rd,
   output logic                RegWrite,
   output logic                MemtoReg,
   output logic                pc_we,
   output logic                pc_sel,
   output logic                illegal,
   output logic [31:0]         retired,
   output logic [2:0]          state
);

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXECUTE = 3'd2,
      S_MEM     = 3'd3,
      S_WB      = 3'd4,
      S_TRAP    = 3'd5
   } state_t;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   state_t      state_q, state_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] retired_q, retired_d;
   // Set by reset, cleared one cycle after rst drops: keeps imem_req low for
   // the whole reset period without a combinational path from rst.
   logic        in_rst_q, in_rst_d;

   logic [6:0]  opcode;
   logic        is_r, is_i, is_ld, is_st, is_br, legal;

   assign opcode = instr_q[6:0];
   assign is_r   = (opcode == OP_R);
   assign is_i   = (opcode == OP_I);
   assign is_ld  = (opcode == OP_LD);
   assign is_st  = (opcode == OP_ST);
   assign is_br  = (opcode == OP_BR);
   assign legal  = is_r | is_i | is_ld | is_st | is_br;

   // Fields decode from the latched instruction, so they are stable from
   // DECODE until the next fetch completes and read 0 after reset.
   always_comb begin
      rs1    = instr_q[19:15];
      rs2    = instr_q[24:20];
      rd     = instr_q[11:7];
      funct3 = instr_q[14:12];
      funct7 = is_r ? instr_q[31:25] : 7'd0;
      ALUSrc = is_i | is_ld | is_st;
      ALUOp  = 2'b00;
      imm32  = 32'd0;
      if (is_br) ALUOp = 2'b01;
      if (is_r)  ALUOp = 2'b10;
      if (is_i)  ALUOp = 2'b11;
      if (is_i || is_ld) imm32 = {{20{instr_q[31]}}, instr_q[31:20]};
      if (is_st) imm32 = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      if (is_br) imm32 = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                          instr_q[30:25], instr_q[11:8], 1'b0};
   end

   // Next state and strobes. pc_sel follows doBranch in branch EXECUTE and a
   // store commits pc_we in its dmem_ack cycle: the PC commit lands in the
   // instruction's last cycle, as the cycle counts require.
   always_comb begin
      state_d      = state_q;
      instr_d      = instr_q;
      retired_d    = retired_q;
      in_rst_d     = 1'b0;
      bus.imem_req = 1'b0;
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
      RegWrite     = 1'b0;
      MemtoReg     = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = 1'b0;
      case (state_q)
         S_FETCH: begin
            bus.imem_req = !in_rst_q;
            if (!in_rst_q && bus.imem_ack) begin
               instr_d = bus.instr;
               state_d = S_DECODE;
            end
         end
         S_DECODE: state_d = legal ? S_EXECUTE : S_TRAP;
         S_EXECUTE: begin
            if (is_br) begin
               pc_we   = 1'b1;
               pc_sel  = doBranch;
               state_d = S_FETCH;
            end else if (is_ld || is_st) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            bus.MemRead  = is_ld;
            bus.MemWrite = is_st;
            if (bus.dmem_ack) begin
               if (is_ld) begin
                  state_d = S_WB;
               end else begin
                  pc_we   = 1'b1;
                  state_d = S_FETCH;
               end
            end
         end
         S_WB: begin
            RegWrite = (instr_q[11:7] != 5'd0);
            MemtoReg = is_ld;
            pc_we    = 1'b1;
            state_d  = S_FETCH;
         end
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_FETCH;
      endcase
      if (pc_we) retired_d = retired_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         instr_q   <= 32'd0;
         retired_q <= 32'd0;
         in_rst_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         retired_q <= retired_d;
         in_rst_q  <= in_rst_d;
      end
   end

   assign illegal = (state_q == S_TRAP);
   assign retired = retired_q;
   assign state   = state_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: one task per scenario, inline checks.
module tb_cpu_control_fsm;
   logic        clk = 1'b0;
   logic        rst;
   logic        doBranch;
   logic [1:0]  ALUOp;
   logic        ALUSrc;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm32;
   logic [4:0]  rs1, rs2, rd;
   logic        RegWrite, MemtoReg, pc_we, pc_sel, illegal;
   logic [31:0] retired;
   logic [2:0]  state;
   logic [102:0] all_out;

   int checks = 0;
   int fails  = 0;

   cpu_control_fsm_if bus ();

   cpu_control_fsm dut (
      .clk(clk), .rst(rst), .bus(bus), .doBranch(doBranch),
      .ALUOp(ALUOp), .ALUSrc(ALUSrc), .funct3(funct3), .funct7(funct7),
      .imm32(imm32), .rs1(rs1), .rs2(rs2), .rd(rd),
      .RegWrite(RegWrite), .MemtoReg(MemtoReg), .pc_we(pc_we),
      .pc_sel(pc_sel), .illegal(illegal), .retired(retired), .state(state)
   );

   always #5 clk = ~clk;

   assign all_out = {bus.imem_req, bus.MemRead, bus.MemWrite, ALUOp, ALUSrc,
                     funct3, funct7, imm32, rs1, rs2, rd, RegWrite, MemtoReg,
                     pc_we, pc_sel, illegal, retired, state};

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   // Reset, release, and land in the first FETCH cycle with imem_ack=1.
   task automatic start(input logic [31:0] i);
      bus.instr = i; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
      doBranch = 1'b0; rst = 1'b1;
      cyc; cyc;
      rst = 1'b0;
      cyc;
      bus.imem_ack = 1'b1;
      #1;
   endtask

   task automatic test_reset;
      bus.instr = 32'h002081B3; bus.imem_ack = 1'b1; bus.dmem_ack = 1'b1;
      doBranch = 1'b1; rst = 1'b1;
      cyc; cyc;
      checks++;
      if (all_out !== 103'd0) begin
         fails++; $display("FAIL reset_outputs: got %h want 0", all_out);
      end
      rst = 1'b0; #1;
      checks++;
      if (all_out !== 103'd0) begin
         fails++; $display("FAIL reset_release_cycle: got %h want 0", all_out);
      end
      cyc;
      checks++;
      if ({bus.imem_req, state} !== {1'b1, 3'd0}) begin
         fails++; $display("FAIL reset_first_req: got %b want 1000", {bus.imem_req, state});
      end
   endtask

   task automatic test_add;
      start(32'h002081B3);
      checks++;
      if ({state, bus.imem_req} !== {3'd0, 1'b1}) begin
         fails++; $display("FAIL add_fetch: got %b want 0001", {state, bus.imem_req});
      end
      cyc;
      checks++;
      if ({state, bus.imem_req, rs1, rs2, rd} !== {3'd1, 1'b0, 5'd1, 5'd2, 5'd3}) begin
         fails++; $display("FAIL add_decode: got %h", {state, bus.imem_req, rs1, rs2, rd});
      end
      cyc;
      checks++;
      if ({state, ALUOp, ALUSrc, funct7, rd, pc_we} !== {3'd2, 2'b10, 1'b0, 7'h00, 5'd3, 1'b0}) begin
         fails++; $display("FAIL add_execute: got %h want %h",
            {state, ALUOp, ALUSrc, funct7, rd, pc_we}, {3'd2, 2'b10, 1'b0, 7'h00, 5'd3, 1'b0});
      end
      cyc;
      bus.imem_ack = 1'b0;
      checks++;
      if ({state, RegWrite, MemtoReg, pc_we, pc_sel, retired} !== {3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0}) begin
         fails++; $display("FAIL add_wb: got %h want %h",
            {state, RegWrite, MemtoReg, pc_we, pc_sel, retired}, {3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0});
      end
      cyc;
      checks++;
      if ({state, pc_we, RegWrite, retired} !== {3'd0, 1'b0, 1'b0, 32'd1}) begin
         fails++; $display("FAIL add_retire: got %h want %h",
            {state, pc_we, RegWrite, retired}, {3'd0, 1'b0, 1'b0, 32'd1});
      end
   endtask

   task automatic test_sub;
      start(32'h402081B3);
      cyc;
      checks++;
      if (funct7 !== 7'h20) begin
         fails++; $display("FAIL sub_decode_funct7: got %h want 20", funct7);
      end
      cyc;
      checks++;
      if ({state, funct7, ALUOp} !== {3'd2, 7'h20, 2'b10}) begin
         fails++; $display("FAIL sub_execute: got %h want %h", {state, funct7, ALUOp}, {3'd2, 7'h20, 2'b10});
      end
   endtask

   task automatic test_addi;
      start(32'hFFF00093);
      cyc; cyc;
      checks++;
      if ({state, imm32, ALUSrc, ALUOp, funct7} !== {3'd2, 32'hFFFFFFFF, 1'b1, 2'b11, 7'h00}) begin
         fails++; $display("FAIL addi_execute: got %h want %h",
            {state, imm32, ALUSrc, ALUOp, funct7}, {3'd2, 32'hFFFFFFFF, 1'b1, 2'b11, 7'h00});
      end
      cyc;
      checks++;
      if ({state, RegWrite, pc_we, rd} !== {3'd4, 1'b1, 1'b1, 5'd1}) begin
         fails++; $display("FAIL addi_wb: got %h want %h", {state, RegWrite, pc_we, rd}, {3'd4, 1'b1, 1'b1, 5'd1});
      end
      // addi x0,x0,1: rd=0 must not write the register file
      start(32'h00100013);
      cyc; cyc;
      checks++;
      if (imm32 !== 32'd1) begin
         fails++; $display("FAIL addi_x0_imm: got %h want 00000001", imm32);
      end
      cyc;
      checks++;
      if ({state, RegWrite, pc_we} !== {3'd4, 1'b0, 1'b1}) begin
         fails++; $display("FAIL addi_x0_wb: got %b want 10001", {state, RegWrite, pc_we});
      end
   endtask

   // beq taken then not taken, fetched back to back with zero-wait imem.
   task automatic test_back_to_back;
      start(32'h00208463);
      doBranch = 1'b1;
      cyc;
      checks++;
      if ({state, pc_we, pc_sel} !== {3'd1, 1'b0, 1'b0}) begin
         fails++; $display("FAIL beq_decode: got %b want 00100", {state, pc_we, pc_sel});
      end
      cyc;
      checks++;
      if ({state, ALUOp, ALUSrc, imm32, pc_we, pc_sel, RegWrite} !== {3'd2, 2'b01, 1'b0, 32'h8, 1'b1, 1'b1, 1'b0}) begin
         fails++; $display("FAIL beq_taken_execute: got %h want %h",
            {state, ALUOp, ALUSrc, imm32, pc_we, pc_sel, RegWrite}, {3'd2, 2'b01, 1'b0, 32'h8, 1'b1, 1'b1, 1'b0});
      end
      cyc;
      checks++;
      if ({state, pc_we, retired} !== {3'd0, 1'b0, 32'd1}) begin
         fails++; $display("FAIL beq_taken_retire: got %h want %h", {state, pc_we, retired}, {3'd0, 1'b0, 32'd1});
      end
      doBranch = 1'b0;
      cyc; cyc;
      checks++;
      if ({state, pc_we, pc_sel, RegWrite} !== {3'd2, 1'b1, 1'b0, 1'b0}) begin
         fails++; $display("FAIL beq_not_taken_execute: got %b want 010100", {state, pc_we, pc_sel, RegWrite});
      end
      bus.imem_ack = 1'b0;
      cyc;
      checks++;
      if ({state, retired} !== {3'd0, 32'd2}) begin
         fails++; $display("FAIL beq_back_to_back_retired: got %h want %h", {state, retired}, {3'd0, 32'd2});
      end
   endtask

   // sw x2,-4(x1) with one dmem wait cycle.
   task automatic test_store;
      start(32'hFE20AE23);
      bus.dmem_ack = 1'b0;
      cyc; cyc;
      checks++;
      if ({state, ALUOp, ALUSrc, imm32, rs2, funct3} !== {3'd2, 2'b00, 1'b1, 32'hFFFFFFFC, 5'd2, 3'b010}) begin
         fails++; $display("FAIL sw_execute: got %h want %h",
            {state, ALUOp, ALUSrc, imm32, rs2, funct3}, {3'd2, 2'b00, 1'b1, 32'hFFFFFFFC, 5'd2, 3'b010});
      end
      cyc;
      checks++;
      if ({state, bus.MemWrite, bus.MemRead, pc_we} !== {3'd3, 1'b1, 1'b0, 1'b0}) begin
         fails++; $display("FAIL sw_mem_wait: got %b want 011100", {state, bus.MemWrite, bus.MemRead, pc_we});
      end
      bus.dmem_ack = 1'b1; #1;
      checks++;
      if ({bus.MemWrite, pc_we, pc_sel, RegWrite} !== {1'b1, 1'b1, 1'b0, 1'b0}) begin
         fails++; $display("FAIL sw_mem_ack: got %b want 1100", {bus.MemWrite, pc_we, pc_sel, RegWrite});
      end
      bus.imem_ack = 1'b0;
      cyc;
      bus.dmem_ack = 1'b0;
      checks++;
      if ({state, bus.MemWrite, retired} !== {3'd0, 1'b0, 32'd1}) begin
         fails++; $display("FAIL sw_retire: got %h want %h", {state, bus.MemWrite, retired}, {3'd0, 1'b0, 32'd1});
      end
   endtask

   // lw x3,4(x1): dmem_ack withheld for the first three MEM cycles.
   task automatic test_load;
      int n, reads, memc;
      logic done;
      start(32'h0040A183);
      n = 1; reads = 0; memc = 0; done = 1'b0;
      for (int k = 0; k < 30 && !done; k++) begin
         cyc;
         bus.imem_ack = 1'b0;
         if (state == 3'd3) begin
            memc++;
            bus.dmem_ack = (memc == 4);
            #1;
         end else begin
            bus.dmem_ack = 1'b0;
         end
         if (bus.MemRead) reads++;
         if (state == 3'd2) begin
            checks++;
            if ({imm32, ALUOp, ALUSrc} !== {32'd4, 2'b00, 1'b1}) begin
               fails++; $display("FAIL lw_execute: got %h want %h", {imm32, ALUOp, ALUSrc}, {32'd4, 2'b00, 1'b1});
            end
         end
         if (state == 3'd4) begin
            checks++;
            if ({MemtoReg, RegWrite, bus.MemRead, pc_we, rd} !== {1'b1, 1'b1, 1'b0, 1'b1, 5'd3}) begin
               fails++; $display("FAIL lw_wb: got %b want 1101_00011", {MemtoReg, RegWrite, bus.MemRead, pc_we, rd});
            end
         end
         if (state == 3'd0) done = 1'b1;
         else n++;
      end
      checks++;
      if (!done || n != 8) begin
         fails++; $display("FAIL lw_total_cycles: got %0d (done=%0d) want 8", n, done);
      end
      checks++;
      if (reads != 4) begin
         fails++; $display("FAIL lw_memread_cycles: got %0d want 4", reads);
      end
      checks++;
      if (retired !== 32'd1) begin
         fails++; $display("FAIL lw_retired: got %0d want 1", retired);
      end
   endtask

   task automatic test_reset_mid_mem;
      start(32'h0040A183);
      bus.dmem_ack = 1'b0;
      cyc; cyc; cyc;
      checks++;
      if ({state, bus.MemRead} !== {3'd3, 1'b1}) begin
         fails++; $display("FAIL midmem_in_mem: got %b want 0111", {state, bus.MemRead});
      end
      rst = 1'b1;
      cyc;
      checks++;
      if (all_out !== 103'd0) begin
         fails++; $display("FAIL midmem_reset_outputs: got %h want 0", all_out);
      end
      rst = 1'b0; bus.dmem_ack = 1'b1; bus.imem_ack = 1'b0;
      cyc;
      checks++;
      if ({state, bus.MemRead, retired, bus.imem_req} !== {3'd0, 1'b0, 32'd0, 1'b1}) begin
         fails++; $display("FAIL midmem_restart: got %h want %h",
            {state, bus.MemRead, retired, bus.imem_req}, {3'd0, 1'b0, 32'd0, 1'b1});
      end
      cyc;
      checks++;
      if ({state, pc_we, RegWrite, retired} !== {3'd0, 1'b0, 1'b0, 32'd0}) begin
         fails++; $display("FAIL midmem_late_ack: got %h want 0", {state, pc_we, RegWrite, retired});
      end
      bus.dmem_ack = 1'b0;
   endtask

   task automatic test_trap;
      int bad;
      start(32'hFFFFFFFF);
      cyc;
      checks++;
      if ({state, illegal} !== {3'd1, 1'b0}) begin
         fails++; $display("FAIL trap_decode: got %b want 0010", {state, illegal});
      end
      cyc;
      checks++;
      if ({state, illegal, bus.imem_req} !== {3'd5, 1'b1, 1'b0}) begin
         fails++; $display("FAIL trap_enter: got %b want 10110", {state, illegal, bus.imem_req});
      end
      bad = 0;
      bus.dmem_ack = 1'b1;
      for (int k = 0; k < 20; k++) begin
         cyc;
         if (bus.imem_req || bus.MemRead || bus.MemWrite || RegWrite || pc_we ||
             state != 3'd5 || !illegal) bad++;
      end
      checks++;
      if (bad != 0) begin
         fails++; $display("FAIL trap_hold: %0d bad cycles of 20, want 0", bad);
      end
      rst = 1'b1;
      cyc;
      checks++;
      if ({illegal, state, retired} !== {1'b0, 3'd0, 32'd0}) begin
         fails++; $display("FAIL trap_reset: got %h want 0", {illegal, state, retired});
      end
      rst = 1'b0;
      cyc;
      checks++;
      if ({bus.imem_req, state, illegal} !== {1'b1, 3'd0, 1'b0}) begin
         fails++; $display("FAIL trap_refetch: got %b want 10000", {bus.imem_req, state, illegal});
      end
      bus.dmem_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1; doBranch = 1'b0;
      bus.instr = 32'd0; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
      test_reset;
      test_add;
      test_sub;
      test_addi;
      test_back_to_back;
      test_store;
      test_load;
      test_reset_mid_mem;
      test_trap;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
